// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY transmit path: link states, byte payload and default timing constants.
package phy_tx_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] COM_SYMBOL = 8'hBC;

    localparam int unsigned DEF_TRAIN_WORDS   = 16;
    localparam int unsigned DEF_SKIP_INTERVAL = 64;
    localparam int unsigned DEF_SKIP_LEN      = 2;

    typedef enum logic [1:0] {
        ST_TRAIN  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SKIP   = 2'd2
    } link_state_e;

    typedef struct packed {
        logic              src;
        logic [DATA_W-1:0] data;
    } tx_byte_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last gets priority on contention.
module rr_arb2 (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = prio ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Priority flips to the other requester after every grant; idle cycles leave it alone.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/tx_byte_scheduler.sv
// Byte-domain transmit scheduler: link training/skip sequencing plus round-robin hand-off of one byte per cycle.
module tx_byte_scheduler
    import phy_tx_pkg::*;
#(
    parameter int unsigned TRAIN_WORDS   = DEF_TRAIN_WORDS,
    parameter int unsigned SKIP_INTERVAL = DEF_SKIP_INTERVAL,
    parameter int unsigned SKIP_LEN      = DEF_SKIP_LEN
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic              link_en,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid_in0,
    output logic              ready0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              valid_in1,
    output logic              ready1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              src_out,
    output logic              link_up
);

    localparam int unsigned CNT_W = $clog2(max2(TRAIN_WORDS, SKIP_INTERVAL)) + 1;

    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_WORDS - 1);
    localparam logic [CNT_W-1:0] SKIP_AT    = CNT_W'(SKIP_INTERVAL - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST  = CNT_W'(SKIP_LEN - 1);

    link_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        gnt;
    logic              arb_en;
    tx_byte_t          out_q;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q <= ST_TRAIN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and slot counter; a dropped link_en overrides any pending transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            ST_TRAIN: begin
                if (cnt_q == TRAIN_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q == SKIP_AT) begin
                    state_d = ST_SKIP;
                    cnt_d   = '0;
                end
            end
            ST_SKIP: begin
                if (cnt_q == SKIP_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_TRAIN;
                cnt_d   = '0;
            end
        endcase
        if (!link_en) begin
            state_d = ST_TRAIN;
            cnt_d   = '0;
        end
    end

    // Grants are withheld in the cycle link_en falls so no byte is taken into a dying link.
    assign arb_en = (state_q == ST_ACTIVE) && link_en;

    rr_arb2 u_arb (
        .clk_4f (clk_4f),
        .reset  (reset),
        .en     (arb_en),
        .req    ({valid_in1, valid_in0}),
        .gnt    (gnt)
    );

    assign ready0 = gnt[0];
    assign ready1 = gnt[1];

    // Output register: payload and source hold between transfers, only valid_out drops.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            valid_out <= 1'b0;
            link_up   <= 1'b0;
        end else begin
            valid_out <= |gnt;
            link_up   <= (state_d != ST_TRAIN);
            if (|gnt) begin
                out_q.src  <= gnt[1];
                out_q.data <= gnt[1] ? data_in1 : data_in0;
            end
        end
    end

    assign data_out = out_q.data;
    assign src_out  = out_q.src;

endmodule

// File: tb/tb_tx_byte_scheduler.sv
// Directed self-checking bench for tx_byte_scheduler with default timing parameters.
module tb_tx_byte_scheduler;

    logic       clk_4f;
    logic       reset;
    logic       link_en;
    logic [7:0] data_in0;
    logic       valid_in0;
    logic       ready0;
    logic [7:0] data_in1;
    logic       valid_in1;
    logic       ready1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       src_out;
    logic       link_up;

    int tests_run;
    int tests_failed;

    tx_byte_scheduler dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .link_en   (link_en),
        .data_in0  (data_in0),
        .valid_in0 (valid_in0),
        .ready0    (ready0),
        .data_in1  (data_in1),
        .valid_in1 (valid_in1),
        .ready1    (ready1),
        .data_out  (data_out),
        .valid_out (valid_out),
        .src_out   (src_out),
        .link_up   (link_up)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    // Reset pulse followed by the 16-slot training phase; returns in the first ACTIVE cycle.
    task automatic bring_up();
        valid_in0 = 1'b0;
        valid_in1 = 1'b0;
        data_in0  = 8'h00;
        data_in1  = 8'h00;
        link_en   = 1'b1;
        reset     = 1'b0;
        step();
        reset = 1'b1;
        repeat (16) step();
    endtask

    task automatic test_reset();
        link_en   = 1'b1;
        valid_in0 = 1'b1;
        valid_in1 = 1'b1;
        data_in0  = 8'h77;
        data_in1  = 8'h88;
        reset     = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({data_out, valid_out, src_out, link_up} !== 11'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got data=%h v=%b s=%b up=%b, expected all zero",
                         data_out, valid_out, src_out, link_up);
            end
            tests_run++;
            if ({ready0, ready1} !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_readys: got %b%b expected 00", ready1, ready0);
            end
            step();
        end
    endtask

    task automatic test_training();
        valid_in1 = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if ({ready0, ready1, valid_out, link_up} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL train_slot%0d: got r0=%b r1=%b v=%b up=%b expected 0000",
                         i, ready0, ready1, valid_out, link_up);
            end
            step();
        end
        tests_run++;
        if ({link_up, ready0, ready1} !== 3'b110) begin
            tests_failed++;
            $display("FAIL train_first_active: got up=%b r0=%b r1=%b expected 1 1 0",
                     link_up, ready0, ready1);
        end
        step();
        tests_run++;
        if ({valid_out, src_out, data_out} !== {1'b1, 1'b0, 8'h77}) begin
            tests_failed++;
            $display("FAIL train_first_byte: got v=%b s=%b d=%h expected 1 0 77",
                     valid_out, src_out, data_out);
        end
    endtask

    task automatic test_alternation();
        logic [7:0] exp_d;
        bring_up();
        data_in0  = 8'hA5;
        data_in1  = 8'h5A;
        valid_in0 = 1'b1;
        valid_in1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            tests_run++;
            if ({ready1, ready0} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL alt_ready%0d: got %b%b expected %s", k, ready1, ready0,
                         (k % 2 == 0) ? "01" : "10");
            end
            step();
            exp_d = (k % 2 == 0) ? 8'hA5 : 8'h5A;
            tests_run++;
            if ({valid_out, src_out, data_out} !== {1'b1, (k % 2 == 1), exp_d}) begin
                tests_failed++;
                $display("FAIL alt_out%0d: got v=%b s=%b d=%h expected 1 %0d %h",
                         k, valid_out, src_out, data_out, k % 2, exp_d);
            end
        end
    endtask

    task automatic test_skip_window();
        logic r0;
        logic exp_r;
        logic [7:0] exp_d;
        bring_up();
        data_in0  = 8'h00;
        valid_in0 = 1'b1;
        for (int k = 0; k < 70; k++) begin
            #1;
            exp_r = !(k == 64 || k == 65);
            r0 = ready0;
            tests_run++;
            if (ready0 !== exp_r) begin
                tests_failed++;
                $display("FAIL skip_ready%0d: got %b expected %b", k, ready0, exp_r);
            end
            step();
            tests_run++;
            if (valid_out !== exp_r) begin
                tests_failed++;
                $display("FAIL skip_valid%0d: got %b expected %b", k, valid_out, exp_r);
            end
            if (exp_r) begin
                exp_d = (k < 64) ? 8'(k) : 8'(k - 2);
                tests_run++;
                if (data_out !== exp_d) begin
                    tests_failed++;
                    $display("FAIL skip_data%0d: got %h expected %h", k, data_out, exp_d);
                end
            end
            if (r0) data_in0 = data_in0 + 8'h01;
        end
        valid_in0 = 1'b0;
    endtask

    task automatic test_single_gaps();
        logic       pat_v [4];
        logic [7:0] pat_d [4];
        logic [7:0] exp_d [4];
        pat_v = '{1'b1, 1'b0, 1'b1, 1'b1};
        pat_d = '{8'h11, 8'h00, 8'h22, 8'h33};
        exp_d = '{8'h11, 8'h11, 8'h22, 8'h33};
        bring_up();
        for (int k = 0; k < 4; k++) begin
            valid_in1 = pat_v[k];
            data_in1  = pat_d[k];
            #1;
            tests_run++;
            if ({ready1, ready0} !== {pat_v[k], 1'b0}) begin
                tests_failed++;
                $display("FAIL gap_ready%0d: got %b%b expected %b0", k, ready1, ready0, pat_v[k]);
            end
            step();
            tests_run++;
            if ({valid_out, src_out, data_out} !== {pat_v[k], 1'b1, exp_d[k]}) begin
                tests_failed++;
                $display("FAIL gap_out%0d: got v=%b s=%b d=%h expected %b 1 %h",
                         k, valid_out, src_out, data_out, pat_v[k], exp_d[k]);
            end
        end
        valid_in1 = 1'b0;
    endtask

    task automatic test_link_disable();
        logic r0;
        bring_up();
        data_in0  = 8'h40;
        valid_in0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            r0 = ready0;
            step();
            tests_run++;
            if (data_out !== 8'(8'h40 + k)) begin
                tests_failed++;
                $display("FAIL ld_stream%0d: got %h expected %h", k, data_out, 8'(8'h40 + k));
            end
            if (r0) data_in0 = data_in0 + 8'h01;
        end
        link_en = 1'b0;
        #1;
        tests_run++;
        if (ready0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL ld_ready_on_drop: got %b expected 0", ready0);
        end
        step();
        tests_run++;
        if ({ready0, ready1, link_up, valid_out} !== 4'b0000 || data_out !== 8'h44) begin
            tests_failed++;
            $display("FAIL ld_after_drop: got r0=%b r1=%b up=%b v=%b d=%h expected 0 0 0 0 44",
                     ready0, ready1, link_up, valid_out, data_out);
        end
        repeat (2) step();
        link_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if ({ready0, valid_out, link_up} !== 3'b000) begin
                tests_failed++;
                $display("FAIL ld_retrain%0d: got r0=%b v=%b up=%b expected 000",
                         i, ready0, valid_out, link_up);
            end
            step();
        end
        tests_run++;
        if ({ready0, link_up} !== 2'b11) begin
            tests_failed++;
            $display("FAIL ld_resume_ready: got r0=%b up=%b expected 11", ready0, link_up);
        end
        step();
        tests_run++;
        if ({valid_out, src_out, data_out} !== {1'b1, 1'b0, 8'h45}) begin
            tests_failed++;
            $display("FAIL ld_resume_byte: got v=%b s=%b d=%h expected 1 0 45",
                     valid_out, src_out, data_out);
        end
        valid_in0 = 1'b0;
    endtask

    task automatic test_async_reset();
        bring_up();
        data_in0  = 8'h99;
        valid_in0 = 1'b1;
        #1;
        step();
        tests_run++;
        if ({valid_out, data_out, link_up} !== {1'b1, 8'h99, 1'b1}) begin
            tests_failed++;
            $display("FAIL ar_before: got v=%b d=%h up=%b expected 1 99 1",
                     valid_out, data_out, link_up);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({valid_out, data_out, link_up, src_out, ready0} !== 12'h0) begin
            tests_failed++;
            $display("FAIL ar_clear: got v=%b d=%h up=%b s=%b r0=%b expected all zero",
                     valid_out, data_out, link_up, src_out, ready0);
        end
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests_run++;
            if ({ready0, valid_out} !== 2'b00) begin
                tests_failed++;
                $display("FAIL ar_retrain%0d: got r0=%b v=%b expected 00", i, ready0, valid_out);
            end
            step();
        end
        tests_run++;
        if ({ready0, link_up} !== 2'b11) begin
            tests_failed++;
            $display("FAIL ar_resume: got r0=%b up=%b expected 11", ready0, link_up);
        end
        valid_in0 = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        link_en      = 1'b0;
        valid_in0    = 1'b0;
        valid_in1    = 1'b0;
        data_in0     = 8'h00;
        data_in1     = 8'h00;
        test_reset();
        test_training();
        test_alternation();
        test_skip_window();
        test_single_gaps();
        test_link_disable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tx_byte_scheduler.md
# tx_byte_scheduler

Transmit-side controller that sits in front of the parallel-to-serial converter in the PCI physical-layer transmit path, in the `clk_4f` byte domain. It arbitrates round-robin between two byte requesters and hands one byte per cycle to the serializer. It also sequences the link:
- a training phase after reset or link enable, during which only idle/COM is sent;
- periodic skip windows that force idle bytes so the receiver can re-align.

When `valid_out` is low, the serializer emits its idle/COM pattern (0xBC).

## Interface
- `TRAIN_WORDS`, 16: number of idle byte slots sent after reset or link enable before data is accepted (≥1).
- `SKIP_INTERVAL`, 64: number of ACTIVE cycles between skip windows (≥2).
- `SKIP_LEN`, 2: number of forced idle slots per skip window (≥1).
- `clk_4f`  in  1  byte clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `link_en`  in  1  link enable; low forces the block back to training.
- `data_in0`  in  8  requester 0 byte.
- `valid_in0`  in  1  requester 0 has a byte.
- `ready0`  out  1  requester 0 byte is taken this cycle.
- `data_in1`  in  8  requester 1 byte.
- `valid_in1`  in  1  requester 1 has a byte.
- `ready1`  out  1  requester 1 byte is taken this cycle.
- `data_out`  out  8  byte to the serializer (`data_demux_32_8` side).
- `valid_out`  out  1  `data_out` is payload; low means the serializer sends idle/COM.
- `src_out`  out  1  source of the current `data_out` (0/1).
- `link_up`  out  1  high while in ACTIVE or SKIP.

## Operation
- **States:** TRAIN, ACTIVE, SKIP. One counter `cnt`, width clog2(max(TRAIN_WORDS, SKIP_INTERVAL)) + 1.
- **TRAIN**
  - Readys low, `valid_out` = 0.
  - `cnt` increments each cycle while `link_en` = 1.
  - At `cnt` == TRAIN_WORDS−1: go to ACTIVE and clear `cnt`.
  - `link_en` = 0 holds `cnt` at 0.
- **ACTIVE**
  - `cnt` counts every cycle, whether or not there is traffic.
  - At `cnt` == SKIP_INTERVAL−1: go to SKIP and clear `cnt`.
- **SKIP**
  - Readys low, `valid_out` = 0.
  - At `cnt` == SKIP_LEN−1: go to ACTIVE and clear `cnt`.
- **Link disable:** `link_en` = 0 in any state → TRAIN next cycle with `cnt` = 0.
- **Arbitration (ACTIVE only)**
  - `prio` bit, reset 0.
  - Only one valid: that requester gets ready.
  - Both valid: requester `prio` gets ready.
  - After any grant to i, `prio` ← ~i.
  - Neither valid: no grant, `prio` unchanged.
- **Ready** is combinational from registered state/`cnt`/`prio` and the current valids.
  - A transfer occurs when `valid_inX` && `readyX`.
  - At most one ready is high per cycle.
- **Requester rules:** requesters keep data stable and `valid_inX` high until accepted. A refused byte is never dropped or duplicated.
- **Output register:** on a transfer, `data_out` ← the granted byte, `src_out` ← i, `valid_out` ← 1 on the next edge. Otherwise `valid_out` ← 0, and `data_out`/`src_out` hold their previous values.
- **Bandwidth:** one byte per `clk_4f` equals eight `clk_32f` serializer bits, which matches serializer throughput exactly. No buffering is required.

## Timing
- **Reset values:** `data_out` 0, `valid_out` 0, `src_out` 0, `link_up` 0, state TRAIN, `cnt` 0, `prio` 0. Readys are 0 while `reset` is low.
- **Latency:** a transfer at edge N appears on `data_out`/`valid_out` after edge N.
- **`link_up`** is registered: high from the first ACTIVE cycle, i.e. TRAIN_WORDS cycles after the first edge with `reset` high and `link_en` high. It stays high through SKIP and drops the cycle after `link_en` falls.
- **ACTIVE → SKIP:** the last ACTIVE cycle can still transfer. The first SKIP cycle shows that byte on `valid_out`; the following SKIP_LEN slots show `valid_out` low.
- **Reset mid-operation:** all outputs clear immediately (asynchronous). The block restarts from TRAIN. In-flight bytes are lost; requesters must re-present them.
- **Coincident events:**
  - `link_en` fall coinciding with SKIP_INTERVAL expiry: TRAIN wins.
  - Simultaneous valids on the last ACTIVE cycle: normal arbitration applies.

## Structure
- **Shared package `phy_tx_pkg`:**
  - state enum (TRAIN/ACTIVE/SKIP);
  - `COM_SYMBOL` = 8'hBC;
  - default TRAIN_WORDS, SKIP_INTERVAL, SKIP_LEN constants.
- **Sub-module `rr_arb2`:** two-way round-robin arbiter.
  - Inputs: `req[1:0]`, `en`, `clk_4f`, `reset`.
  - Outputs: `gnt[1:0]`; owns the `prio` bit.
- The top level holds the state machine, counter, and output register.

## Test plan
- **Training:** reset low 3 cycles, then high with `link_en` = 1 and defaults. Expect `valid_out` = 0 and readys 0 for 16 cycles, then `link_up` = 1 and ready0 = 1 in the first ACTIVE cycle when `valid_in0` = 1.
- **Alternation:** both valid continuously, `data_in0` = 0xA5, `data_in1` = 0x5A. Expect `data_out` sequence A5, 5A, A5, … with `src_out` 0, 1, 0, … and `valid_out` high every ACTIVE cycle.
- **Skip window:** requester 0 streams an incrementing 0x00, 0x01, … with defaults.
  - After 64 ACTIVE cycles, ready0 is low and `valid_out` is low for exactly 2 slots.
  - Streaming then resumes, and the output sequence is gap-free in value with no loss or duplication.
- **Single requester with gaps:** `valid_in1` pattern 1, 0, 1, 1 with data 0x11, –, 0x22, 0x33. Expect outputs 0x11 / idle / 0x22 / 0x33 one cycle later, with `src_out` = 1.
- **Link disable:** drop `link_en` during streaming. Next cycle: readys 0, `link_up` 0, `valid_out` 0. Re-raise `link_en`: 16 idle slots, then data resumes from the unaccepted byte.
- **Async reset:** assert reset between clock edges while `valid_out` = 1. Expect `data_out`, `valid_out`, and `link_up` to go 0 without a clock edge, followed by a full retrain.
